// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package regfile_arb_pkg;

    typedef enum logic {CLEAR, RUN} arb_state_t;
    typedef enum logic {REQ_ALU, REQ_MEM} req_id_t;

    localparam int CLEAR_W = 32;
    localparam logic [CLEAR_W-1:0] CLEAR_DATA = '0;

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// Two-way round-robin arbiter: grant is combinational from req, priority advances on en.
// Latency: 0 cycles req->grant; last-grant updates on the enabled edge.
// Backpressure: a requester not granted simply keeps req high; no state is kept for it.
module rr_arbiter_2
    import regfile_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

    req_id_t last_grant_q;
    req_id_t last_grant_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= REQ_MEM;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    // Bit 0 is ALU, bit 1 is MEM; on conflict the side not served last wins.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant_q == REQ_MEM) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (en && (grant != 2'b00)) begin
            last_grant_d = grant[0] ? REQ_ALU : REQ_MEM;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Clears every register after reset, then round-robins ALU/load writebacks onto WE3/A3/WD3.
// Latency: handshake at edge k appears on the write port after edge k (one register stage).
// Backpressure: ready is combinational; the losing requester holds valid and payload until ready.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int M = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         alu_valid,
    input  logic [N-1:0] alu_addr,
    input  logic [M-1:0] alu_data,
    output logic         alu_ready,
    input  logic         mem_valid,
    input  logic [N-1:0] mem_addr,
    input  logic [M-1:0] mem_data,
    output logic         mem_ready,
    output logic         WE3,
    output logic [N-1:0] A3,
    output logic [M-1:0] WD3,
    output logic         busy,
    output logic         pc_drop
);

    localparam logic [N-1:0] LAST_ADDR = '1;

    arb_state_t   state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic         we3_q, we3_d;
    logic [N-1:0] a3_q, a3_d;
    logic [M-1:0] wd3_q, wd3_d;
    logic         pc_drop_q, pc_drop_d;

    logic [1:0]   grant;
    logic         xfer;
    logic [N-1:0] sel_addr;
    logic [M-1:0] sel_data;

    rr_arbiter_2 u_rr (
        .clk   (clk),
        .rst   (rst),
        .req   ({mem_valid, alu_valid}),
        .en    (xfer),
        .grant (grant)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if ((state_q == CLEAR) && (cnt_q == LAST_ADDR)) begin
            state_d = RUN;
        end
    end

    // Output logic
    always_comb begin
        alu_ready = (state_q == RUN) & grant[0];
        mem_ready = (state_q == RUN) & grant[1];
        busy      = (state_q == CLEAR);
    end

    assign xfer     = alu_ready | mem_ready;
    assign sel_addr = grant[0] ? alu_addr : mem_addr;
    assign sel_data = grant[0] ? alu_data : mem_data;

    // Write-port datapath; A3/WD3 hold on idle and dropped cycles.
    always_comb begin
        cnt_d     = cnt_q;
        we3_d     = 1'b0;
        a3_d      = a3_q;
        wd3_d     = wd3_q;
        pc_drop_d = 1'b0;
        if (state_q == CLEAR) begin
            we3_d = 1'b1;
            a3_d  = cnt_q;
            wd3_d = M'(CLEAR_DATA);
            cnt_d = cnt_q + 1'b1;
        end else if (xfer) begin
            if (sel_addr == LAST_ADDR) begin
                pc_drop_d = 1'b1;
            end else begin
                we3_d = 1'b1;
                a3_d  = sel_addr;
                wd3_d = sel_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            we3_q     <= 1'b0;
            a3_q      <= '0;
            wd3_q     <= '0;
            pc_drop_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            we3_q     <= we3_d;
            a3_q      <= a3_d;
            wd3_q     <= wd3_d;
            pc_drop_q <= pc_drop_d;
        end
    end

    assign WE3     = we3_q;
    assign A3      = a3_q;
    assign WD3     = wd3_q;
    assign pc_drop = pc_drop_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: clear sequence, vector table in RUN, mid-run reset.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid;
    logic [3:0]  alu_addr, mem_addr;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready;
    logic        WE3, busy, pc_drop;
    logic [3:0]  A3;
    logic [31:0] WD3;

    int checks = 0;
    int errors = 0;

    logic [31:0] rf [16];

    always #5 clk = ~clk;

    regfile_write_arbiter #(.N(4), .M(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .WE3       (WE3),
        .A3        (A3),
        .WD3       (WD3),
        .busy      (busy),
        .pc_drop   (pc_drop)
    );

    // Register file downstream of the write port.
    always @(posedge clk) begin
        if (WE3) rf[A3] <= WD3;
    end

    typedef struct {
        logic        av;
        logic [3:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [3:0]  ma;
        logic [31:0] md;
        logic        e_ardy;
        logic        e_mrdy;
        logic        e_we;
        logic [3:0]  e_a3;
        logic [31:0] e_wd;
        logic        e_pc;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_clear(input string tag);
        for (int i = 0; i < 16; i++) begin
            #1;
            chk($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'd1);
            chk($sformatf("%s_rdy%0d", tag, i), {30'd0, alu_ready, mem_ready}, 32'd0);
            tick();
            chk($sformatf("%s_we%0d", tag, i), 32'(WE3), 32'd1);
            chk($sformatf("%s_a3_%0d", tag, i), 32'(A3), 32'(i));
            chk($sformatf("%s_wd%0d", tag, i), WD3, 32'd0);
        end
    endtask

    initial begin
        //          av  aa  ad            mv  ma  md        ardy mrdy we a3  wd            pc
        vecs[0]  = '{1, 1,  32'h11,       1, 2,  32'h22,   1,   0,   1, 1,  32'h11,       0};
        vecs[1]  = '{1, 1,  32'h11,       1, 2,  32'h22,   0,   1,   1, 2,  32'h22,       0};
        vecs[2]  = '{1, 1,  32'h11,       1, 2,  32'h22,   1,   0,   1, 1,  32'h11,       0};
        vecs[3]  = '{1, 1,  32'h11,       1, 2,  32'h22,   0,   1,   1, 2,  32'h22,       0};
        vecs[4]  = '{1, 5,  32'hA,        1, 5,  32'hB,    1,   0,   1, 5,  32'hA,        0};
        vecs[5]  = '{1, 5,  32'hA,        1, 5,  32'hB,    0,   1,   1, 5,  32'hB,        0};
        vecs[6]  = '{0, 0,  32'h0,        0, 0,  32'h0,    0,   0,   0, 5,  32'hB,        0};
        vecs[7]  = '{1, 3,  32'hDEADBEEF, 0, 0,  32'h0,    1,   0,   1, 3,  32'hDEADBEEF, 0};
        vecs[8]  = '{0, 0,  32'h0,        1, 15, 32'h1234, 0,   1,   0, 3,  32'hDEADBEEF, 1};
        vecs[9]  = '{1, 7,  32'h77,       1, 8,  32'h88,   1,   0,   1, 7,  32'h77,       0};
        vecs[10] = '{0, 0,  32'h0,        1, 8,  32'h88,   0,   1,   1, 8,  32'h88,       0};
        vecs[11] = '{1, 15, 32'h99,       0, 0,  32'h0,    1,   0,   0, 8,  32'h88,       1};
        vecs[12] = '{0, 0,  32'h0,        0, 0,  32'h0,    0,   0,   0, 8,  32'h88,       0};

        rst = 1'b1;
        alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 32'h11;
        mem_valid = 1'b1; mem_addr = 4'd2; mem_data = 32'h22;
        tick();
        tick();
        chk("rst_we", 32'(WE3), 32'd0);
        chk("rst_a3", 32'(A3), 32'd0);
        chk("rst_wd", WD3, 32'd0);
        chk("rst_pc", 32'(pc_drop), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_rdy", {30'd0, alu_ready, mem_ready}, 32'd0);
        rst = 1'b0;

        run_clear("clr");

        for (int i = 0; i < 13; i++) begin
            alu_valid = vecs[i].av; alu_addr = vecs[i].aa; alu_data = vecs[i].ad;
            mem_valid = vecs[i].mv; mem_addr = vecs[i].ma; mem_data = vecs[i].md;
            #1;
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
            chk($sformatf("v%0d_alu_rdy", i), 32'(alu_ready), 32'(vecs[i].e_ardy));
            chk($sformatf("v%0d_mem_rdy", i), 32'(mem_ready), 32'(vecs[i].e_mrdy));
            tick();
            chk($sformatf("v%0d_we", i), 32'(WE3), 32'(vecs[i].e_we));
            chk($sformatf("v%0d_a3", i), 32'(A3), 32'(vecs[i].e_a3));
            chk($sformatf("v%0d_wd", i), WD3, vecs[i].e_wd);
            chk($sformatf("v%0d_pc", i), 32'(pc_drop), 32'(vecs[i].e_pc));
        end
        chk("rf5_final", rf[5], 32'hB);
        chk("rf3_final", rf[3], 32'hDEADBEEF);
        chk("rf15_untouched", rf[15], 32'h0);

        // Continuous ALU traffic, then reset in the middle of it.
        alu_valid = 1'b1; alu_addr = 4'd4;
        mem_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            alu_data = 32'h100 + 32'(k);
            #1;
            chk($sformatf("bb%0d_rdy", k), 32'(alu_ready), 32'd1);
            tick();
            chk($sformatf("bb%0d_we", k), 32'(WE3), 32'd1);
            chk($sformatf("bb%0d_wd", k), WD3, 32'h100 + 32'(k));
        end
        rst = 1'b1;
        tick();
        chk("mrst_rdy", {30'd0, alu_ready, mem_ready}, 32'd0);
        chk("mrst_busy", 32'(busy), 32'd1);
        chk("mrst_we", 32'(WE3), 32'd0);
        chk("mrst_a3", 32'(A3), 32'd0);
        rst = 1'b0;
        run_clear("mclr");
        #1;
        chk("mclr_done_rdy", 32'(alu_ready), 32'd1);
        chk("mclr_done_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Sequencer and arbiter for the single write port (WE3/A3/WD3) of the register file. After reset it walks every register address and writes zero, then shares the write port between two writeback requesters (ALU and memory-load path) under round-robin priority with a valid/ready handshake. It sits between the writeback stage and the register file, and its registered outputs drive the register file's write port directly.

## Interface
- N, 4: register address width; the file holds 2**N registers.
- M, 32: data width.
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU writeback request.
- alu_addr  in  N  ALU destination register.
- alu_data  in  M  ALU result.
- alu_ready  out  1  ALU request accepted this cycle (valid & ready = transfer).
- mem_valid  in  1  load writeback request.
- mem_addr  in  N  load destination register.
- mem_data  in  M  load data.
- mem_ready  out  1  load request accepted this cycle.
- WE3  out  1  register-file write enable, registered.
- A3  out  N  register-file write address, registered.
- WD3  out  M  register-file write data, registered.
- busy  out  1  high while the clear sequence runs.
- pc_drop  out  1  one-cycle pulse: an accepted write targeted address 2**N-1 and was discarded.

## Operation
- Single clock; reset is synchronous and active-high.
- States: CLEAR, RUN.
- CLEAR:
  - Each cycle registers WE3=1, A3=cnt, WD3=0, then cnt++.
  - When cnt == 2**N-1 is issued, go to RUN.
  - Both readies are 0 and busy is 1.
- RUN:
  - busy=0.
  - Grant rule:
    - Only one valid: that requester is granted.
    - Both valid: the requester not granted most recently is granted. last_grant resets to MEM, so ALU wins the first conflict.
    - No valid: no grant, and last_grant is held.
  - ready is combinational: `ready_x = (state==RUN) & grant_x`. At most one ready per cycle. ready never depends on the requester's own ready.
  - On a transfer to an address other than 2**N-1, register WE3=1, A3=addr, WD3=data.
  - On a transfer to address 2**N-1 (R15/PC, which the datapath supplies externally):
    - WE3=0 and pc_drop=1 for one cycle.
    - The transfer still counts as a grant for round-robin.
  - Cycles with no transfer register WE3=0. A3/WD3 hold their last values.
- Same address from both requesters in one cycle: serviced over two consecutive cycles in round-robin order. The later write wins in the register file.
- The loser of a conflict must keep valid and its payload stable until ready. The arbiter does not latch the payload.
- rst mid-operation, in either state: return to CLEAR with cnt=0 on the next edge. In-flight requests are not accepted, and the clear restarts from address 0.

## Timing
- Reset values (the edge with rst=1): state=CLEAR, cnt=0, last_grant=MEM, WE3=0, A3=0, WD3=0, pc_drop=0. Combinationally, busy=1 and alu_ready=mem_ready=0.
- After rst deasserts, let edge 1 be the first edge. Clear writes appear on the outputs after edges 1..2**N, at addresses 0..2**N-1 in order. State is RUN from edge 2**N, so the first possible ready is in cycle 2**N (cycle 16 for N=4).
- Transfer latency:
  - A handshake at edge k shows on WE3/A3/WD3 after edge k.
  - The register file captures the write at edge k+1.
  - Throughput is one write per cycle, with no bubbles between back-to-back transfers.
- pc_drop is asserted in the same cycle that WE3 would have shown the write.

## Structure
- Package regfile_arb_pkg holds:
  - typedef enum logic {CLEAR, RUN} arb_state_t;
  - typedef enum logic {REQ_ALU, REQ_MEM} req_id_t;
  - the clear data constant (all-zero, width M).
- One sub-module, rr_arbiter_2: inputs req[1:0], output grant[1:0], with an internal last-grant register that advances on an enable (the transfer). It has its own clk/rst.
- The top level holds the state register, the clear counter, the write-port output registers and the pc_drop logic.

## Test plan
- Reset clear:
  - Stimulus: rst high for 2 cycles, then low, with both valids held high.
  - Required: WE3=1 with A3=0..15 and WD3=0 over 16 consecutive cycles; busy=1 throughout; no ready until cycle 16.
- Single requester:
  - Stimulus: in RUN, alu_valid with addr 3 and data 0xDEADBEEF.
  - Required: alu_ready=1 the same cycle; next cycle WE3=1, A3=3, WD3=0xDEADBEEF.
- Conflict round-robin:
  - Stimulus: both valid for 4 cycles (alu addr 1 / 0x11, mem addr 2 / 0x22), holding payloads until ready.
  - Required: grants alternate ALU, MEM, ALU, MEM; A3 sequence 1, 2, 1, 2; never both readies high.
- Same address:
  - Stimulus: alu addr 5 / 0xA, mem addr 5 / 0xB, both valid.
  - Required: A3=5 for two consecutive cycles with WD3 0xA then 0xB, and final register value 0xB.
- PC drop:
  - Stimulus: mem_valid with addr 15 and data 0x1234.
  - Required: mem_ready=1; next cycle WE3=0 and pc_drop=1 for exactly one cycle; the next conflict is granted to ALU.
- Mid-run reset:
  - Stimulus: rst pulsed during continuous ALU traffic.
  - Required: readies drop on the edge after rst; the clear restarts at A3=0 and completes all 16 addresses.
